// File: rtl/countdown_timer_if.sv
// countdown_timer_if: command/status bundle for the MM:SS countdown timer.
//   Commands (master -> slave): tick, load, load_min, load_sec, start, pause, clear
//   Status   (slave -> master): min, sec, running, done, alarm, load_err,
//                               borrowout, state_dbg (FSM state for observers)
// Handshake semantics: there is no valid/ready pair. Every command input is a
// level sampled on each rising clk edge; a command is taken on every edge at
// which it is high. All status outputs except borrowout are registered and
// change on the edge that samples the causing command.
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       done;
    logic       alarm;
    logic       load_err;
    logic       borrowout;
    logic [1:0] state_dbg;

    modport master (
        output tick, load, load_min, load_sec, start, pause, clear,
        input  min, sec, running, done, alarm, load_err, borrowout, state_dbg
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, pause, clear,
        output min, sec, running, done, alarm, load_err, borrowout, state_dbg
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable BCD MM:SS countdown timer driven by a 1 Hz tick.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active HIGH despite the name
//   bus   : countdown_timer_if.slave (commands in, count/flags out)
// Command priority per cycle: clear > load > pause/start > tick.
// done pulses for the first cycle of EXPIRED; alarm holds while EXPIRED.
module countdown_timer #(
    parameter logic [7:0] MAX_MIN = 8'h99
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state, nxt_state;
    logic [7:0] min_q, sec_q;
    logic [7:0] nxt_min, nxt_sec;
    logic [7:0] dec_min, dec_sec;
    logic       running_q, done_q, alarm_q, load_err_q;
    logic       nxt_done, nxt_err;
    logic       load_ok;
    logic       is_zero;

    assign is_zero = (min_q == 8'h00) && (sec_q == 8'h00);

    // A preset is accepted only if it is well-formed BCD within range, so the
    // count can never hold an out-of-range nibble.
    assign load_ok = (bus.load_min[7:4] <= 4'd9) && (bus.load_min[3:0] <= 4'd9) &&
                     (bus.load_sec[7:4] <= 4'd5) && (bus.load_sec[3:0] <= 4'd9) &&
                     (bus.load_min <= MAX_MIN);

    // One-second BCD decrement. Only used in RUN, where the count is never
    // 00:00, so the minutes borrow never underflows.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_q[3:0] - 4'd1;
        end else if (sec_q[7:4] != 4'd0) begin
            dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
        end else begin
            dec_sec = 8'h59;
            if (min_q[3:0] != 4'd0) begin
                dec_min[3:0] = min_q[3:0] - 4'd1;
            end else begin
                dec_min = {min_q[7:4] - 4'd1, 4'd9};
            end
        end
    end

    // Next-state selection. A load in RUN is not applicable, but it still
    // swallows a coincident tick.
    always_comb begin
        nxt_state = state;
        nxt_min   = min_q;
        nxt_sec   = sec_q;
        nxt_done  = 1'b0;
        nxt_err   = 1'b0;
        if (bus.clear) begin
            nxt_state = IDLE;
            nxt_min   = 8'h00;
            nxt_sec   = 8'h00;
        end else if (bus.load && (state != RUN)) begin
            if (load_ok) begin
                nxt_state = IDLE;
                nxt_min   = bus.load_min;
                nxt_sec   = bus.load_sec;
            end else begin
                nxt_err = 1'b1;
            end
        end else if ((state == RUN) && bus.pause) begin
            nxt_state = PAUSE;
        end else if (bus.start && ((state == IDLE) || (state == PAUSE)) && !is_zero) begin
            nxt_state = RUN;
        end else if (bus.tick && (state == RUN) && !bus.load) begin
            nxt_min = dec_min;
            nxt_sec = dec_sec;
            if ((min_q == 8'h00) && (sec_q == 8'h01)) begin
                nxt_state = EXPIRED;
                nxt_done  = 1'b1;
            end
        end
    end

    // Flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state      <= nxt_state;
            min_q      <= nxt_min;
            sec_q      <= nxt_sec;
            running_q  <= (nxt_state == RUN);
            done_q     <= nxt_done;
            alarm_q    <= (nxt_state == EXPIRED);
            load_err_q <= nxt_err;
        end
    end

    assign bus.min       = min_q;
    assign bus.sec       = sec_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.alarm     = alarm_q;
    assign bus.load_err  = load_err_q;
    assign bus.borrowout = is_zero;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed test of countdown_timer against a bench model
// that tracks the remaining time as a plain number of seconds.
module tb_countdown_timer;

    localparam logic [7:0] MAX_MIN_P = 8'h99;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP  = 3;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    countdown_timer_if bus ();

    countdown_timer #(.MAX_MIN(MAX_MIN_P)) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int m_t;      // remaining seconds
    int m_st;
    bit m_done;
    bit m_err;

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic bit preset_ok(input logic [7:0] m, input logic [7:0] s);
        if (m[7:4] > 4'd9 || m[3:0] > 4'd9 || s[7:4] > 4'd9 || s[3:0] > 4'd9) return 1'b0;
        if (bcd2i(s) > 59) return 1'b0;
        if (bcd2i(m) > bcd2i(MAX_MIN_P)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_st = M_IDLE; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (bus.clear) begin
                m_t = 0; m_st = M_IDLE;
            end else if (bus.load && m_st != M_RUN) begin
                if (preset_ok(bus.load_min, bus.load_sec)) begin
                    m_t  = bcd2i(bus.load_min) * 60 + bcd2i(bus.load_sec);
                    m_st = M_IDLE;
                end else begin
                    m_err = 1'b1;
                end
            end else if (m_st == M_RUN && bus.pause) begin
                m_st = M_PAUSE;
            end else if (bus.start && (m_st == M_IDLE || m_st == M_PAUSE) && m_t != 0) begin
                m_st = M_RUN;
            end else if (bus.tick && m_st == M_RUN && !bus.load) begin
                m_t = m_t - 1;
                if (m_t == 0) begin
                    m_st = M_EXP; m_done = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("min",       32'(bus.min),       32'(i2b(m_t / 60)));
        check("sec",       32'(bus.sec),       32'(i2b(m_t % 60)));
        check("running",   32'(bus.running),   32'(m_st == M_RUN));
        check("alarm",     32'(bus.alarm),     32'(m_st == M_EXP));
        check("done",      32'(bus.done),      32'(m_done));
        check("load_err",  32'(bus.load_err),  32'(m_err));
        check("borrowout", 32'(bus.borrowout), 32'(m_t == 0));
    end

    // ---------------- driver ----------------
    task automatic drive_idle();
        bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
        bus.pause = 1'b0; bus.clear = 1'b0;
        bus.load_min = 8'h00; bus.load_sec = 8'h00;
    endtask

    // Called at posedge+1; applies inputs for one edge and returns at the
    // following posedge+1 with the inputs dropped.
    task automatic pulse(input logic c_tick, input logic c_load, input logic c_start,
                         input logic c_pause, input logic c_clear,
                         input logic [7:0] lm, input logic [7:0] ls);
        bus.tick = c_tick; bus.load = c_load; bus.start = c_start;
        bus.pause = c_pause; bus.clear = c_clear;
        bus.load_min = lm; bus.load_sec = ls;
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lm, ls);
    endtask
    task automatic do_start();
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask
    task automatic do_tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask
    task automatic do_pause();
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask
    task automatic do_clear();
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    endtask
    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        drive_idle();
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        check("lit_reset_min", 32'(bus.min), 32'h00);
        check("lit_reset_borrow", 32'(bus.borrowout), 32'h1);
        do_start();
        check("lit_start_at_zero", 32'(bus.running), 32'h0);

        // 00:03 down to expiry
        do_load(8'h00, 8'h03);
        do_start();
        check("lit_running", 32'(bus.running), 32'h1);
        do_tick();
        check("lit_sec02", 32'(bus.sec), 32'h02);
        do_tick();
        check("lit_sec01", 32'(bus.sec), 32'h01);
        do_tick();
        check("lit_sec00", 32'(bus.sec), 32'h00);
        check("lit_done", 32'(bus.done), 32'h1);
        check("lit_alarm", 32'(bus.alarm), 32'h1);
        check("lit_run_off", 32'(bus.running), 32'h0);
        wait_cycles(1);
        check("lit_done_once", 32'(bus.done), 32'h0);
        check("lit_alarm_held", 32'(bus.alarm), 32'h1);
        do_tick();
        do_start();
        check("lit_exp_start_ign", 32'(bus.running), 32'h0);

        // minute borrows, load out of EXPIRED clears alarm
        do_load(8'h10, 8'h00);
        check("lit_alarm_clr", 32'(bus.alarm), 32'h0);
        do_start();
        do_tick();
        check("lit_0959", {bus.min, bus.sec}, 32'h0959);
        do_pause();
        do_load(8'h01, 8'h00);
        do_start();
        do_tick();
        check("lit_0059", {bus.min, bus.sec}, 32'h0059);
        do_load(8'h00, 8'h10);   // ignored in RUN
        check("lit_run_load_err", 32'(bus.load_err), 32'h0);
        check("lit_run_load_ign", {bus.min, bus.sec}, 32'h0059);
        do_pause();

        // invalid loads in PAUSE
        do_load(8'h00, 8'h60);
        check("lit_err_sec60", 32'(bus.load_err), 32'h1);
        wait_cycles(1);
        check("lit_err_pulse", 32'(bus.load_err), 32'h0);
        do_load(8'h1A, 8'h00);
        check("lit_err_min1a", 32'(bus.load_err), 32'h1);
        do_load(8'hA0, 8'h00);
        check("lit_err_max", 32'(bus.load_err), 32'h1);
        check("lit_err_keep", {bus.min, bus.sec}, 32'h0059);
        do_load(8'h99, 8'h59);
        check("lit_9959", {bus.min, bus.sec}, 32'h9959);

        // collisions
        do_load(8'h05, 8'h00);
        do_start();
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("lit_pause_tick", {bus.min, bus.sec}, 32'h0500);
        check("lit_paused", 32'(bus.running), 32'h0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        check("lit_resume", 32'(bus.running), 32'h1);
        do_tick();
        check("lit_0459", {bus.min, bus.sec}, 32'h0459);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00);
        check("lit_clr_load", {bus.min, bus.sec}, 32'h0000);

        // back-to-back ticks, then async reset mid-cycle
        do_load(8'h02, 8'h32);
        do_start();
        do_tick();
        do_tick();
        check("lit_0230", {bus.min, bus.sec}, 32'h0230);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("lit_async_min", 32'(bus.min), 32'h00);
        check("lit_async_run", 32'(bus.running), 32'h0);
        check("lit_async_borrow", 32'(bus.borrowout), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_load(8'h00, 8'h02);
        do_start();
        do_tick();
        check("lit_0001", {bus.min, bus.sec}, 32'h0001);
        do_tick();
        check("lit_exp2", 32'(bus.alarm), 32'h1);
        do_clear();
        check("lit_clear_alarm", 32'(bus.alarm), 32'h0);
        do_start();
        check("lit_idle_after_clr", 32'(bus.running), 32'h0);
        wait_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable MM:SS countdown timer for the digital clock. It is the down-counting counterpart of the up-counting time-keeping counters. It decrements a BCD minutes/seconds value once per 1 Hz tick, and it signals expiry with a one-cycle `done` pulse and a held `alarm` level. It sits beside the timekeeping chain and shares the same `tick` enable and display path.

## Interface
- `MAX_MIN`, default 8'h99: largest accepted BCD minutes preset. A load above this is rejected.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-high reset. High = reset, despite the name.
- `tick` in 1: 1 Hz enable, one `clk` cycle wide.
- `load` in 1: load preset from `load_min`/`load_sec`.
- `load_min` in 8: BCD minutes preset, 00..MAX_MIN.
- `load_sec` in 8: BCD seconds preset, 00..59.
- `start` in 1: begin or resume counting.
- `pause` in 1: suspend counting.
- `clear` in 1: return to IDLE with count 00:00.
- `min` out 8: current BCD minutes.
- `sec` out 8: current BCD seconds.
- `running` out 1: high while in RUN.
- `done` out 1: one-cycle pulse on expiry.
- `alarm` out 1: high while in EXPIRED.
- `load_err` out 1: one-cycle pulse on a rejected load.
- `borrowout` out 1: combinational, high when count == 00:00.

## Operation
- States and entry:
  - IDLE: after reset, clear, or a valid load.
  - RUN: counting.
  - PAUSE: frozen.
  - EXPIRED: count reached 00:00 from RUN.
- Command priority per cycle: `clear` > `load` > `pause`/`start` > `tick`. Only the highest-priority applicable action takes effect.
- `clear`, any state:
  - Next state IDLE, count 00:00.
  - `alarm`, `done`, `running` all 0.
- `load`:
  - Accepted in IDLE, PAUSE and EXPIRED. Ignored in RUN; no `load_err`.
  - Valid when every nibble ≤ 9, `load_sec` ≤ 8'h59 and `load_min` ≤ MAX_MIN.
  - Valid load: count ← preset, next state IDLE, `alarm` cleared.
  - Invalid load: count and state unchanged, `load_err` pulses.
- `start`:
  - From IDLE or PAUSE with count ≠ 00:00: next state RUN.
  - With count 00:00: ignored.
  - In EXPIRED: ignored; `load` or `clear` is needed to leave EXPIRED.
- `pause`:
  - In RUN: next state PAUSE.
  - If `start` and `pause` are both high: in RUN, `pause` wins; in PAUSE, `start` wins.
- `tick` in RUN with no higher-priority command: decrement by one second, BCD.
  - Seconds low nibble 0 → 9, with a borrow from the tens nibble.
  - Seconds 00 → 59, with a borrow from minutes. Minutes decrement the same way.
  - When the count goes 00:01 → 00:00, the next state is EXPIRED.
- `tick` dropped cases:
  - Outside RUN, `tick` is ignored.
  - A `tick` coinciding with `pause`, `load` or `clear` is dropped.
- Width rule: `min` and `sec` always hold valid BCD. No state produces a nibble > 9, `sec` > 59 or `min` > MAX_MIN.

## Timing
- Reset values: state IDLE, `min`=8'h00, `sec`=8'h00, `running`=0, `done`=0, `alarm`=0, `load_err`=0, `borrowout`=1.
- `rst_n` asserted mid-count forces reset values immediately, asynchronously. The first command is accepted on the first edge after `rst_n` falls.
- All outputs except `borrowout` are registered and change on the edge that samples the causing input.
  - Latency: 1 cycle from command/tick to outputs.
- `running` is high exactly in the cycles where state is RUN.
- `done` is high for exactly the first cycle of EXPIRED. It is never re-asserted without leaving and re-entering EXPIRED.
- `alarm` rises with `done` and stays high until `clear` or a valid `load` (1-cycle latency).
- `load_err` is high for one cycle after the rejecting edge.
- Back-to-back ticks on consecutive cycles each decrement; there is no minimum tick spacing.

## Test plan
- Reset then release → min=00, sec=00, all flags 0, borrowout=1; start alone is ignored.
- Load 00:03, start, 3 ticks → sec 02, 01, 00. `done` pulses one cycle on the 3rd tick edge, `alarm`=1, `running`=0, and a 4th tick changes nothing.
- Load 10:00, start, 1 tick → 09:59. Load 01:00, start, 1 tick → 00:59. Load 99:59 with MAX_MIN=8'h99 → accepted.
- Invalid loads: load_sec=8'h60, load_min=8'h1A, and load_min above MAX_MIN → each gives a `load_err` one-cycle pulse and leaves count unchanged. A load during RUN is ignored and gives no `load_err`.
- Command collisions:
  - RUN at 05:00 with pause and tick in the same cycle → PAUSE, count stays 05:00.
  - start and pause together in PAUSE → RUN.
  - clear with load together → 00:00, IDLE.
- Reset and clear recovery:
  - Assert `rst_n` between clock edges mid-RUN at 02:30 → outputs go to reset values immediately; after release, load/start works normally.
  - In EXPIRED, clear → `alarm`=0, IDLE.
